// File: rtl/ldl_rr_arb_bin.sv
// Round-robin arbiter over 2^BIN_WIDTH requesters. The winner is presented as a registered
// binary index with a valid/ready handshake, meant to drive a binary-to-one-hot decoder.
module ldl_rr_arb_bin #(
  parameter int unsigned BIN_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [(1<<BIN_WIDTH)-1:0] req,
  input  logic                     lock,
  input  logic                     gnt_ready,
  output logic                     gnt_vld,
  output logic [BIN_WIDTH-1:0]     gnt_idx
);

  localparam int unsigned N = 1 << BIN_WIDTH;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
  logic [BIN_WIDTH-1:0] ptr_q, ptr_d;
  logic [BIN_WIDTH-1:0] base;
  logic [BIN_WIDTH-1:0] cand;
  logic [BIN_WIDTH-1:0] winner;
  logic                 accept;
  logic                 any_req;

  assign accept  = (state_q == StGrant) && gnt_ready;
  assign any_req = |req;
  // On acceptance the just-granted index becomes the new priority base in the same cycle.
  assign base    = accept ? gnt_idx_q : ptr_q;

  // Scan from lowest to highest priority so the last hit (closest to base+1) wins;
  // i == N wraps back to base itself, giving it the lowest priority.
  always_comb begin
    winner = base;
    cand   = base;
    for (int i = N; i >= 1; i--) begin
      cand = base + BIN_WIDTH'(i);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_idx_d = winner;
          state_d   = StGrant;
        end
      end
      StGrant: begin
        if (gnt_ready) begin
          ptr_d = gnt_idx_q;
          if (lock && req[gnt_idx_q]) begin
            gnt_idx_d = gnt_idx_q;
          end else if (any_req) begin
            gnt_idx_d = winner;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_idx_q <= '0;
      ptr_q     <= BIN_WIDTH'(N - 1);
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt_vld = (state_q == StGrant);
  assign gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_ldl_rr_arb_bin.sv
// Bench for ldl_rr_arb_bin: directed scenarios on 4- and 16-requester instances plus
// randomized traffic compared against a queue-free arithmetic round-robin model.
module tb_ldl_rr_arb_bin;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req2 = '0;
  logic        lock2 = 1'b0;
  logic        rdy2 = 1'b0;
  logic        gnt_vld2;
  logic [1:0]  gnt_idx2;
  logic [15:0] req4 = '0;
  logic        lock4 = 1'b0;
  logic        rdy4 = 1'b0;
  logic        gnt_vld4;
  logic [3:0]  gnt_idx4;
  logic [15:0] y4;

  int errors = 0;
  int checks = 0;

  // Reference model state, one per instance.
  bit m2_vld, m4_vld;
  int m2_idx, m2_ptr, m4_idx, m4_ptr;

  always #5 clk = ~clk;

  ldl_rr_arb_bin #(.BIN_WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req2),
    .lock      (lock2),
    .gnt_ready (rdy2),
    .gnt_vld   (gnt_vld2),
    .gnt_idx   (gnt_idx2)
  );

  ldl_rr_arb_bin #(.BIN_WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req4),
    .lock      (lock4),
    .gnt_ready (rdy4),
    .gnt_vld   (gnt_vld4),
    .gnt_idx   (gnt_idx4)
  );

  // Behavioural stand-in for the downstream one-hot decoder.
  assign y4 = gnt_vld4 ? (16'h0001 << gnt_idx4) : 16'h0000;

  function automatic int rr_pick(input int n, input logic [15:0] r, input int base);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (base + k) % n;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_next(input int n, input logic [15:0] r, input logic lk, input logic rd,
                            input bit vld, input int idx, input int ptr,
                            output bit nv, output int ni, output int np);
    int w;
    nv = vld; ni = idx; np = ptr;
    if (!vld) begin
      w = rr_pick(n, r, ptr);
      if (w >= 0) begin nv = 1'b1; ni = w; end
    end else if (rd) begin
      np = idx;
      if (!(lk && r[idx])) begin
        w = rr_pick(n, r, idx);
        if (w >= 0) ni = w;
        else nv = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m2_vld = 1'b0; m2_idx = 0; m2_ptr = 3;
    m4_vld = 1'b0; m4_idx = 0; m4_ptr = 15;
  endtask

  task automatic tick();
    bit v2, v4;
    int i2, p2, i4, p4;
    model_next(4, {12'b0, req2}, lock2, rdy2, m2_vld, m2_idx, m2_ptr, v2, i2, p2);
    model_next(16, req4, lock4, rdy4, m4_vld, m4_idx, m4_ptr, v4, i4, p4);
    @(posedge clk);
    m2_vld = v2; m2_idx = i2; m2_ptr = p2;
    m4_vld = v4; m4_idx = i4; m4_ptr = p4;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    checks++;
    if (gnt_vld2 !== 1'b0 || gnt_idx2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_w2: vld=%b idx=%0d, want vld=0 idx=0", gnt_vld2, gnt_idx2);
    end
    checks++;
    if (gnt_vld4 !== 1'b0 || gnt_idx4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_w4: vld=%b idx=%0d, want vld=0 idx=0", gnt_vld4, gnt_idx4);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    rdy2 = 1'b1; req2 = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 2'd2) begin
        errors++;
        $display("FAIL single[%0d]: vld=%b idx=%0d, want vld=1 idx=2", c, gnt_vld2, gnt_idx2);
      end
    end
    req2 = 4'b0000;
    tick();
    checks++;
    if (gnt_vld2 !== 1'b0) begin
      errors++;
      $display("FAIL single_drop: vld=%b, want 0", gnt_vld2);
    end
  endtask

  task automatic test_fairness();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    rdy2 = 1'b1; req2 = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 2'(exp_seq[c])) begin
        errors++;
        $display("FAIL fairness[%0d]: vld=%b idx=%0d, want vld=1 idx=%0d",
                 c, gnt_vld2, gnt_idx2, exp_seq[c]);
      end
    end
    req2 = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy2 = 1'b0; req2 = 4'b1010;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 2'd1) begin
        errors++;
        $display("FAIL stall[%0d]: vld=%b idx=%0d, want vld=1 idx=1", c, gnt_vld2, gnt_idx2);
      end
      if (c == 1) req2 = 4'b0010;
      tick();
    end
    rdy2 = 1'b1;
    tick();
    checks++;
    if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 2'd1) begin
      errors++;
      $display("FAIL after_stall: vld=%b idx=%0d, want vld=1 idx=1", gnt_vld2, gnt_idx2);
    end
    req2 = 4'b0000;
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    rdy2 = 1'b1; req2 = 4'b1111; lock2 = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 2'd0) begin
        errors++;
        $display("FAIL lock_hold[%0d]: vld=%b idx=%0d, want vld=1 idx=0", c, gnt_vld2, gnt_idx2);
      end
    end
    lock2 = 1'b0;
    tick();
    checks++;
    if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 2'd1) begin
      errors++;
      $display("FAIL lock_release: vld=%b idx=%0d, want vld=1 idx=1", gnt_vld2, gnt_idx2);
    end
    req2 = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    rdy2 = 1'b0; req2 = 4'b1000;
    tick();
    checks++;
    if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 2'd3) begin
      errors++;
      $display("FAIL pre_reset: vld=%b idx=%0d, want vld=1 idx=3", gnt_vld2, gnt_idx2);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gnt_vld2 !== 1'b0 || gnt_idx2 !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: vld=%b idx=%0d, want vld=0 idx=0", gnt_vld2, gnt_idx2);
    end
    req2 = 4'b1001; rdy2 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_first: vld=%b idx=%0d, want vld=1 idx=0", gnt_vld2, gnt_idx2);
    end
    tick();
    checks++;
    if (gnt_vld2 !== 1'b1 || gnt_idx2 !== 2'd3) begin
      errors++;
      $display("FAIL post_reset_second: vld=%b idx=%0d, want vld=1 idx=3", gnt_vld2, gnt_idx2);
    end
    req2 = 4'b0000;
    tick();
  endtask

  task automatic test_decoder();
    logic [15:0] want;
    do_reset();
    checks++;
    if (y4 !== 16'h0000) begin
      errors++;
      $display("FAIL dec_idle: y=%h, want 0000", y4);
    end
    rdy4 = 1'b1; req4 = 16'hFFFF;
    for (int c = 0; c < 17; c++) begin
      tick();
      want = 16'h0001 << (c % 16);
      checks++;
      if (y4 !== want) begin
        errors++;
        $display("FAIL dec_walk[%0d]: y=%h, want %h", c, y4, want);
      end
    end
    req4 = 16'h0000;
    tick();
    checks++;
    if (y4 !== 16'h0000) begin
      errors++;
      $display("FAIL dec_drop: y=%h, want 0000", y4);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req2  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      lock2 = ($urandom_range(0, 3) == 0);
      rdy2  = ($urandom_range(0, 2) != 0);
      req4  = ($urandom_range(0, 4) == 0) ? 16'h0000 : (16'($urandom) & 16'($urandom));
      lock4 = ($urandom_range(0, 3) == 0);
      rdy4  = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (gnt_vld2 !== m2_vld || (m2_vld && gnt_idx2 !== 2'(m2_idx))) begin
        errors++;
        $display("FAIL rand_w2[%0d]: vld=%b idx=%0d, want vld=%b idx=%0d",
                 c, gnt_vld2, gnt_idx2, m2_vld, m2_idx);
      end
      checks++;
      if (gnt_vld4 !== m4_vld || (m4_vld && gnt_idx4 !== 4'(m4_idx))) begin
        errors++;
        $display("FAIL rand_w4[%0d]: vld=%b idx=%0d, want vld=%b idx=%0d",
                 c, gnt_vld4, gnt_idx4, m4_vld, m4_idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_lock();
    test_async_reset();
    test_decoder();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldl_rr_arb_bin.md
Name: ldl_rr_arb_bin

Overview:
Round-robin arbiter across 2^BIN_WIDTH requesters. Emits the winning requester as a registered binary index with a valid/ready handshake. Sits directly upstream of the team's binary-to-one-hot decoder: gnt_idx drives the decoder's x, and gnt_vld drives its en, so the decoder produces the one-hot grant/select vector. The arbiter owns fairness and handshake timing; the decoder stays purely combinational.

Parameters:
BIN_WIDTH, 4, width of the grant index; number of requesters N = 1<<BIN_WIDTH (BIN_WIDTH >= 1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector, bit i = requester i
lock  input  1  when high at handshake, the same index is re-granted next (burst hold)
gnt_ready  input  1  downstream accepts current grant
gnt_vld  output  1  grant valid (feeds decoder en)
gnt_idx  output  BIN_WIDTH  granted requester index (feeds decoder x)

Behaviour:
- Reset (rst_n low, asynchronous, any time): gnt_vld=0, gnt_idx=0, priority pointer ptr=N-1, so requester 0 has highest priority first. Deassertion takes effect synchronously at the next clk edge.
- State machine with two states:
  - IDLE (gnt_vld=0): at each edge, if req!=0, register winner into gnt_idx, set gnt_vld=1, go to GRANT. Otherwise stay in IDLE.
  - GRANT (gnt_vld=1): gnt_idx and gnt_vld are held stable while gnt_ready=0, even if req changes or drops. This is a valid-stability rule.
- Handshake: a grant is accepted on any edge with gnt_vld=1 and gnt_ready=1. On acceptance:
  - ptr <= gnt_idx.
  - If lock=1 and req[gnt_idx]=1: gnt_idx unchanged, gnt_vld stays 1, ptr still updated.
  - Else if any req bit set: new winner computed from the current req using updated priority (search from gnt_idx+1). It is registered the same edge; gnt_vld stays 1. Back-to-back grants therefore run at one per cycle.
  - Else: gnt_vld <= 0, go to IDLE.
- Arbitration (combinational, from registered ptr, or from gnt_idx on acceptance):
  - Search order is ptr+1, ptr+2, ... modulo N, wrapping from N-1 to 0.
  - The first set req bit wins.
  - The just-accepted index has the lowest priority unless it is the only requester, in which case it wins again.
- Latency: a req asserted in cycle n with the arbiter idle gives gnt_vld=1 in cycle n+1.
- Width: index arithmetic is modulo N (natural BIN_WIDTH-bit wrap). There are no unused index codes.
- lock is ignored when gnt_vld=0 or gnt_ready=0.
- gnt_ready with gnt_vld=0 has no effect.
- Outputs are registered directly from flops, with no combinational path from req or gnt_ready to any output.
- Reset mid-GRANT: the grant is dropped immediately, and arbitration restarts from requester 0 after reset release.

Test Plan:
- Single request, BIN_WIDTH=2, gnt_ready=1:
  - Stimulus: after reset, req=0100 asserted at cycle 0.
  - Required: gnt_vld=1, gnt_idx=2 at cycle 1. With req held, idx=2 is re-granted every cycle. Dropping req gives gnt_vld=0 one cycle after the last acceptance.
- Round-robin fairness, BIN_WIDTH=2:
  - Stimulus: req=1111 continuous, gnt_ready=1.
  - Required: gnt_idx sequence 0,1,2,3,0,1 on consecutive cycles, with gnt_vld constantly 1.
- Backpressure:
  - Stimulus: req=1010, gnt_ready=0 for 5 cycles, with req changed to 0010 during the stall.
  - Required: gnt_idx=1 stays stable with gnt_vld=1 throughout. After gnt_ready=1, next gnt_idx=1 (only requester remaining).
- Lock:
  - Stimulus: req=1111, lock=1 for the accepts of idx 0.
  - Required: idx 0 is re-granted 3 times. After lock=0, the next grant is 1.
- Async reset mid-grant:
  - Stimulus: rst_n pulsed low between edges while gnt_vld=1, gnt_idx=3.
  - Required: gnt_vld=0 and gnt_idx=0 immediately. After release with req=1001, first grant is 0, then 3.
- Decoder integration:
  - Stimulus: instantiate with BIN_WIDTH=4 and the bin2hot decoder, req=all ones.
  - Required: decoder y walks 0001h, 0002h, ... 8000h, 0001h. y=0 whenever gnt_vld=0.
